// File: rtl/ro_puf_pkg.sv
// Shared types and parameter legality helpers for the ring-oscillator PUF core.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      SETTLE,
      CAPTURE,
      FAULT
   } state_t;

   localparam int CLEAR_CYC = 2;

   function automatic bit stages_ok(input int stages);
      return (stages >= 3) && ((stages % 2) == 1);
   endfunction

   function automatic bit sel_w_ok(input int sel_w, input int n_ro);
      return (n_ro >= 2) && (n_ro <= 256) && ((1 << sel_w) >= n_ro);
   endfunction

endpackage

// File: rtl/ro_cell.sv
// One gated ring oscillator plus a saturating edge counter clocked by the ring itself.
// The loop is modelled as STAGES inversions of INV_DLY clk cycles each, so one half period is STAGES*INV_DLY.
module ro_cell
   import ro_puf_pkg::*;
#(
   parameter int STAGES  = 15,
   parameter int CNT_W   = 16,
   parameter int INV_DLY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ro_en,
   input  logic             cnt_clr_n,
   output logic [CNT_W-1:0] count
);

   localparam int HALF = STAGES * INV_DLY;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

   logic [HW-1:0] half_tmr;
   logic          ro_out;

   if (!stages_ok(STAGES) || (INV_DLY < 1)) begin : g_bad_cell
      $error("ro_cell: STAGES must be odd and >= 3, INV_DLY >= 1");
   end

   // The NAND gate parks the loop low whenever the enable is removed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ro_out   <= 1'b0;
         half_tmr <= HW'(HALF - 1);
      end else if (!ro_en) begin
         ro_out   <= 1'b0;
         half_tmr <= HW'(HALF - 1);
      end else if (half_tmr == '0) begin
         ro_out   <= ~ro_out;
         half_tmr <= HW'(HALF - 1);
      end else begin
         half_tmr <= half_tmr - 1'b1;
      end
   end

   always_ff @(posedge ro_out or negedge cnt_clr_n) begin
      if (!cnt_clr_n) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ro_puf_core.sv
// Ring-oscillator PUF measurement core: races two selected cells for a fixed window
// and turns their edge-count comparison into one response bit.
// IDLE wait start | CLEAR zero selected counters | RUN window, two rings on
// SETTLE rings parked, counters quiet | CAPTURE done pulse | FAULT illegal challenge
module ro_puf_core
   import ro_puf_pkg::*;
#(
   parameter int              N_RO        = 16,
   parameter int              SEL_W       = 4,
   parameter int              STAGES      = 15,
   parameter int              CNT_W       = 16,
   parameter int              WIN_CYC     = 1024,
   parameter int              SETTLE_CYC  = 4,
   parameter logic [N_RO*8-1:0] INV_DLY_TBL = {N_RO{8'd1}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*SEL_W-1:0] challenge,
   output logic               busy,
   output logic               done,
   output logic               response,
   output logic               tie,
   output logic               err,
   output logic [CNT_W-1:0]   count_a,
   output logic [CNT_W-1:0]   count_b
);

   localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   if (!stages_ok(STAGES) || !sel_w_ok(SEL_W, N_RO) || (WIN_CYC < 1) || (SETTLE_CYC < 2)) begin : g_bad_cfg
      $error("ro_puf_core: illegal parameter set");
   end

   state_t           state, state_d;
   logic [TMR_W-1:0] tmr, tmr_d;
   logic             tc, accept, capture_now, fault_now;
   logic [SEL_W-1:0] chal_a, chal_b, sel_a, sel_b;
   logic             chal_ok;
   logic [N_RO-1:0]  ro_en;
   logic [CNT_W-1:0] cnt [N_RO];
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic             frozen_raw, frozen_s1, frozen_s2;

   assign chal_a  = challenge[SEL_W-1:0];
   assign chal_b  = challenge[2*SEL_W-1:SEL_W];
   assign chal_ok = (chal_a != chal_b) && (32'(chal_a) < N_RO) && (32'(chal_b) < N_RO);
   assign tc      = (tmr == '0);
   assign busy    = (state == CLEAR) || (state == RUN) || (state == SETTLE) || (state == FAULT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         tmr   <= '0;
      end else begin
         state <= state_d;
         tmr   <= tmr_d;
      end
   end

   always_comb begin
      state_d     = state;
      tmr_d       = tc ? tmr : tmr - 1'b1;
      accept      = 1'b0;
      capture_now = 1'b0;
      fault_now   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (chal_ok) begin
                  state_d = CLEAR;
                  tmr_d   = TMR_W'(CLEAR_CYC - 1);
               end else begin
                  state_d = FAULT;
               end
            end
         end
         CLEAR: begin
            if (tc) begin
               state_d = RUN;
               tmr_d   = TMR_W'(WIN_CYC - 1);
            end
         end
         RUN: begin
            if (tc) begin
               state_d = SETTLE;
               tmr_d   = TMR_W'(SETTLE_CYC - 1);
            end
         end
         SETTLE: begin
            if (tc) begin
               state_d     = CAPTURE;
               capture_now = 1'b1;
            end
         end
         CAPTURE: state_d = IDLE;
         FAULT: begin
            state_d   = IDLE;
            fault_now = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_a <= '0;
         sel_b <= '0;
      end else if (accept) begin
         sel_a <= chal_a;
         sel_b <= chal_b;
      end
   end

   for (genvar i = 0; i < N_RO; i++) begin : g_cell
      localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
      logic hit;
      assign hit      = (sel_a == IDX) || (sel_b == IDX);
      assign ro_en[i] = (state == RUN) && hit;

      ro_cell #(
         .STAGES  (STAGES),
         .CNT_W   (CNT_W),
         .INV_DLY (int'(INV_DLY_TBL[i*8 +: 8]))
      ) u_cell (
         .clk       (clk),
         .rst_n     (rst_n),
         .ro_en     (ro_en[i]),
         .cnt_clr_n (rst_n & ~((state == CLEAR) && hit)),
         .count     (cnt[i])
      );
   end

   always_comb begin
      cnt_a = '0;
      cnt_b = '0;
      for (int i = 0; i < N_RO; i++) begin
         if (SEL_W'(i) == sel_a) cnt_a = cnt[i];
         if (SEL_W'(i) == sel_b) cnt_b = cnt[i];
      end
   end

   // Raised on the edge that parks the rings, so with SETTLE_CYC >= 2 the re-timed
   // copy is already high when the counters are sampled.
   assign frozen_raw = (state == SETTLE) || ((state == RUN) && tc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frozen_s1 <= 1'b0;
         frozen_s2 <= 1'b0;
      end else begin
         frozen_s1 <= frozen_raw;
         frozen_s2 <= frozen_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done     <= 1'b0;
         response <= 1'b0;
         tie      <= 1'b0;
         err      <= 1'b0;
         count_a  <= '0;
         count_b  <= '0;
      end else begin
         done <= capture_now | fault_now;
         if (capture_now && frozen_s2) begin
            count_a  <= cnt_a;
            count_b  <= cnt_b;
            response <= (cnt_a > cnt_b);
            tie      <= (cnt_a == cnt_b);
            err      <= 1'b0;
         end else if (fault_now) begin
            count_a  <= '0;
            count_b  <= '0;
            response <= 1'b0;
            tie      <= 1'b0;
            err      <= 1'b1;
         end
      end
   end

endmodule
